// File: rtl/led_sched_pkg.sv
// rtl/led_sched_pkg.sv - shared types and constants for the LED mode scheduler
//
// Purpose: scheduler state encoding, LED mode encodings, dwell lookup
//          helper and LFSR constants used by led_mode_sched and
//          led_sched_lfsr.
// Ports:   none (package).

package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } sched_state_t;

  // Mode encodings as consumed by the LED pattern stage.
  localparam logic [1:0] MODE_LSHIFT = 2'd0;
  localparam logic [1:0] MODE_RSHIFT = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_FIXED  = 2'd3;

  // 7-bit maximal LFSR, polynomial x^7 + x^6 + 1 (taps on bits 6 and 5).
  localparam int         LFSR_W    = 7;
  localparam logic [6:0] LFSR_SEED = 7'h5A;
  localparam logic [6:0] LFSR_TAPS = 7'h60;

  // Dwell time in seconds for a given mode.
  function automatic int dwell_lookup(
    input logic [1:0] m,
    input int         d0,
    input int         d1,
    input int         d2,
    input int         d3
  );
    int d;
    case (m)
      MODE_LSHIFT: d = d0;
      MODE_RSHIFT: d = d1;
      MODE_BLINK:  d = d2;
      default:     d = d3;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/led_sched_lfsr.sv
// rtl/led_sched_lfsr.sv - 7-bit maximal LFSR with advance enable
//
// Purpose: pseudo-random mode source for the scheduler's random build.
//          Shifts left, feedback = lfsr[6] ^ lfsr[5], seeded on reset.
// Ports:
//   clk_1  in   1 Hz sequencer clock
//   rst_n  in   asynchronous active-low reset, loads LFSR_SEED
//   en     in   advance the register by one step this cycle
//   pick   out  low two bits of the current LFSR value

module led_sched_lfsr
  import led_sched_pkg::*;
(
  input  logic       clk_1,
  input  logic       rst_n,
  input  logic       en,
  output logic [1:0] pick
);

  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (en) begin
      lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign pick = lfsr[1:0];

endmodule

// File: rtl/led_mode_sched.sv
// rtl/led_mode_sched.sv - 1 Hz mode sequencer feeding the LED pattern stage
//
// Purpose: steps the LED mode through 0->1->2->3->0, holding each mode for a
//          programmable dwell time, with pause and a forced-mode
//          request/acknowledge handshake. Defining LED_SCHED_RANDOM_EN
//          replaces the sequential advance with an LFSR-chosen next mode.
// Ports:
//   clk_1        in   1 Hz sequencer clock
//   rst_n        in   asynchronous active-low reset
//   enable       in   1 runs the scheduler, 0 returns it to IDLE
//   pause        in   freezes the dwell countdown
//   force_valid  in   force request, held until force_ack
//   force_mode   in   requested mode, stable while force_valid is high
//   force_ack    out  one-cycle acknowledge of an accepted force
//   mode         out  current mode
//   mode_change  out  one-cycle pulse whenever mode is (re)loaded
//   dwell_left   out  seconds left in the current mode, current one included
//   cycle_cnt    out  completed 3->0 wraps (every expiry in random build), saturating
//   running      out  high in RUN or HOLD

module led_mode_sched
  import led_sched_pkg::*;
#(
  parameter int DWELL_W = 4,
  parameter int DWELL0  = 8,
  parameter int DWELL1  = 8,
  parameter int DWELL2  = 6,
  parameter int DWELL3  = 4
) (
  input  logic               clk_1,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               pause,
  input  logic               force_valid,
  input  logic [1:0]         force_mode,
  output logic               force_ack,
  output logic [1:0]         mode,
  output logic               mode_change,
  output logic [DWELL_W-1:0] dwell_left,
  output logic [7:0]         cycle_cnt,
  output logic               running
);

  localparam int DWELL_MAX = (1 << DWELL_W) - 1;

  if (DWELL0 < 1 || DWELL0 > DWELL_MAX || DWELL1 < 1 || DWELL1 > DWELL_MAX ||
      DWELL2 < 1 || DWELL2 > DWELL_MAX || DWELL3 < 1 || DWELL3 > DWELL_MAX)
  begin : g_dwell_range_check
    $error("led_mode_sched: every DWELLn must lie in 1..2^DWELL_W-1");
  end

  function automatic logic [DWELL_W-1:0] dwell_for(input logic [1:0] m);
    return DWELL_W'(dwell_lookup(m, DWELL0, DWELL1, DWELL2, DWELL3));
  endfunction

  sched_state_t state;
  logic [1:0]   next_mode;
  logic         counts_wrap;

`ifdef LED_SCHED_RANDOM_EN
  logic [1:0] lfsr_pick;

  // The LFSR free-runs through every RUN cycle so the chosen mode depends on
  // how long the scheduler has been running, not only on the expiry count.
  led_sched_lfsr u_lfsr (
    .clk_1 (clk_1),
    .rst_n (rst_n),
    .en    (state == RUN),
    .pick  (lfsr_pick)
  );

  // Bump a repeat of the current mode by one so every expiry changes mode.
  always_comb begin
    next_mode = lfsr_pick;
    if (lfsr_pick == mode) begin
      next_mode = mode + 2'd1;
    end
  end

  assign counts_wrap = 1'b1;
`else
  assign next_mode   = mode + 2'd1;
  assign counts_wrap = (mode == MODE_FIXED);
`endif

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode        <= MODE_LSHIFT;
      dwell_left  <= '0;
      cycle_cnt   <= '0;
      mode_change <= 1'b0;
      force_ack   <= 1'b0;
      running     <= 1'b0;
    end else begin
      mode_change <= 1'b0;
      force_ack   <= 1'b0;

      if (!enable) begin
        // Disable beats everything; the wrap count survives for diagnostics.
        state      <= IDLE;
        mode       <= MODE_LSHIFT;
        dwell_left <= '0;
        running    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state       <= RUN;
            mode        <= MODE_LSHIFT;
            dwell_left  <= dwell_for(MODE_LSHIFT);
            mode_change <= 1'b1;
            running     <= 1'b1;
          end

          RUN, HOLD: begin
            running <= 1'b1;
            if (force_valid && !force_ack) begin
              // A force keeps the current state, so a forced mode taken
              // during HOLD stays frozen until pause is released.
              mode        <= force_mode;
              dwell_left  <= dwell_for(force_mode);
              force_ack   <= 1'b1;
              mode_change <= 1'b1;
            end else if (state == HOLD) begin
              if (!pause) begin
                state <= RUN;
              end
            end else if (pause) begin
              state <= HOLD;
            end else if (dwell_left > DWELL_W'(1)) begin
              dwell_left <= dwell_left - DWELL_W'(1);
            end else begin
              mode        <= next_mode;
              dwell_left  <= dwell_for(next_mode);
              mode_change <= 1'b1;
              if (counts_wrap && cycle_cnt != 8'hFF) begin
                cycle_cnt <= cycle_cnt + 8'd1;
              end
            end
          end

          default: begin
            state   <= IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_mode_sched.sv
// tb/tb_led_mode_sched.sv - self-checking bench for led_mode_sched

module tb_led_mode_sched;

  localparam int DW [4] = '{8, 8, 6, 4};

  logic       clk_1 = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       pause = 1'b0;
  logic       force_valid = 1'b0;
  logic [1:0] force_mode = 2'd0;
  logic       force_ack;
  logic [1:0] mode;
  logic       mode_change;
  logic [3:0] dwell_left;
  logic [7:0] cycle_cnt;
  logic       running;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: tracks seconds elapsed in the current mode rather than
  // a countdown; dwell_left is derived as DW[mode] - elapsed.
  bit m_on, m_hold, m_ack, m_mc;
  int m_mode, m_elapsed, m_cnt, m_lfsr;

  always #5 clk_1 = ~clk_1;

  led_mode_sched #(
    .DWELL_W (4),
    .DWELL0  (8),
    .DWELL1  (8),
    .DWELL2  (6),
    .DWELL3  (4)
  ) dut (
    .clk_1       (clk_1),
    .rst_n       (rst_n),
    .enable      (enable),
    .pause       (pause),
    .force_valid (force_valid),
    .force_mode  (force_mode),
    .force_ack   (force_ack),
    .mode        (mode),
    .mode_change (mode_change),
    .dwell_left  (dwell_left),
    .cycle_cnt   (cycle_cnt),
    .running     (running)
  );

  wire [16:0] act_vec = {force_ack, mode, mode_change, dwell_left, cycle_cnt, running};

  function automatic logic [16:0] exp_vec();
    logic [3:0] d;
    d = m_on ? 4'(DW[m_mode] - m_elapsed) : 4'd0;
    return {m_ack, 2'(m_mode), m_mc, d, 8'(m_cnt), m_on};
  endfunction

  task automatic model_reset();
    m_on = 0; m_hold = 0; m_ack = 0; m_mc = 0;
    m_mode = 0; m_elapsed = 0; m_cnt = 0; m_lfsr = 'h5A;
  endtask

  task automatic model_tick(input bit en, input bit pz, input bit fv, input int fm);
    bit prev_ack;
    bit was_run;
    int nxt;
    prev_ack = m_ack;
    was_run  = m_on && !m_hold;
    m_ack = 0;
    m_mc  = 0;
    if (!en) begin
      m_on = 0; m_hold = 0; m_mode = 0; m_elapsed = 0;
    end else if (!m_on) begin
      m_on = 1; m_mode = 0; m_elapsed = 0; m_mc = 1;
    end else if (fv && !prev_ack) begin
      m_mode = fm; m_elapsed = 0; m_ack = 1; m_mc = 1;
    end else if (m_hold) begin
      m_hold = pz;
    end else if (pz) begin
      m_hold = 1;
    end else begin
      m_elapsed++;
      if (m_elapsed == DW[m_mode]) begin
`ifdef LED_SCHED_RANDOM_EN
        nxt = m_lfsr % 4;
        if (nxt == m_mode) nxt = (nxt + 1) % 4;
        if (m_cnt < 255) m_cnt++;
`else
        nxt = (m_mode + 1) % 4;
        if (m_mode == 3 && m_cnt < 255) m_cnt++;
`endif
        m_mode = nxt;
        m_elapsed = 0;
        m_mc = 1;
      end
    end
`ifdef LED_SCHED_RANDOM_EN
    if (was_run) m_lfsr = ((m_lfsr * 2) % 128) + (((m_lfsr >> 6) ^ (m_lfsr >> 5)) & 1);
`else
    if (was_run) m_lfsr = m_lfsr;
`endif
  endtask

  task automatic step(input bit en, input bit pz, input bit fv, input logic [1:0] fm);
    enable = en; pause = pz; force_valid = fv; force_mode = fm;
    @(posedge clk_1);
    model_tick(en, pz, fv, int'(fm));
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (act_vec !== 17'd0) begin
      n_fail++; $display("FAIL reset_async: got %h want %h", act_vec, 17'd0);
    end
    @(posedge clk_1); #1;
    n_checks++;
    if (act_vec !== 17'd0) begin
      n_fail++; $display("FAIL reset_held: got %h want %h", act_vec, 17'd0);
    end
    @(negedge clk_1) rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_start();
    for (int i = 1; i <= 9; i++) begin
      step(1, 0, 0, 2'd0);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL start_seq%0d: got %h want %h", i, act_vec, exp_vec());
      end
      if (i == 1) begin
        n_checks++;
        if ({mode, dwell_left, mode_change, running} !== {2'd0, 4'd8, 1'b1, 1'b1}) begin
          n_fail++; $display("FAIL start_entry: mode %0d dwell %0d mc %0d run %0d want 0 8 1 1",
                             mode, dwell_left, mode_change, running);
        end
      end
`ifndef LED_SCHED_RANDOM_EN
      if (i == 9) begin
        n_checks++;
        if ({mode, dwell_left, mode_change} !== {2'd1, 4'd8, 1'b1}) begin
          n_fail++; $display("FAIL start_first_expiry: mode %0d dwell %0d mc %0d want 1 8 1",
                             mode, dwell_left, mode_change);
        end
      end
`endif
    end
  endtask

  task automatic test_full_cycle();
    for (int i = 10; i <= 27; i++) begin
      step(1, 0, 0, 2'd0);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL cycle_seq%0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
`ifndef LED_SCHED_RANDOM_EN
    n_checks++;
    if ({mode, cycle_cnt} !== {2'd0, 8'd1}) begin
      n_fail++; $display("FAIL cycle_wrap: mode %0d cnt %0d want 0 1", mode, cycle_cnt);
    end
`endif
    for (int i = 0; i < 300 * 26; i++) begin
      step(1, 0, 0, 2'd0);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL cycle_loop%0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
    n_checks++;
    if (cycle_cnt !== 8'd255) begin
      n_fail++; $display("FAIL cycle_saturate: cnt %0d want 255", cycle_cnt);
    end
  endtask

  task automatic test_pause();
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1, 0, 0, 2'd0);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL pause_seek: got %h want %h", act_vec, exp_vec());
      end
      if (dwell_left == 4'd5 && !m_hold) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL pause_reach: dwell %0d never reached 5", dwell_left);
    end
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 2'd0);
      n_checks++;
      if ({dwell_left, running, mode_change} !== {4'd5, 1'b1, 1'b0} || act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL pause_hold%0d: got %h dwell %0d want dwell 5 run 1", i, act_vec, dwell_left);
      end
    end
    step(1, 0, 0, 2'd0);
    n_checks++;
    if (dwell_left !== 4'd5) begin
      n_fail++; $display("FAIL pause_release: dwell %0d want 5", dwell_left);
    end
    step(1, 0, 0, 2'd0);
    n_checks++;
    if (dwell_left !== 4'd4 || act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL pause_resume: dwell %0d want 4", dwell_left);
    end
  endtask

  task automatic test_force_hold();
    step(1, 1, 0, 2'd0);
    step(1, 1, 0, 2'd0);
    step(1, 1, 1, 2'd3);
    n_checks++;
    if ({force_ack, mode, dwell_left, mode_change} !== {1'b1, 2'd3, 4'd4, 1'b1} || act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL force_hold_ack: got %h want ack 1 mode 3 dwell 4 mc 1", act_vec);
    end
    // Requester still holds force_valid during the ack cycle; it must be ignored.
    step(1, 1, 1, 2'd3);
    n_checks++;
    if ({force_ack, mode_change, dwell_left} !== {1'b0, 1'b0, 4'd4}) begin
      n_fail++; $display("FAIL force_hold_ignore: ack %0d mc %0d dwell %0d want 0 0 4",
                         force_ack, mode_change, dwell_left);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 2'd0);
      n_checks++;
      if (dwell_left !== 4'd4 || act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL force_hold_frozen%0d: dwell %0d want 4", i, dwell_left);
      end
    end
    step(1, 0, 0, 2'd0);
    step(1, 0, 0, 2'd0);
    n_checks++;
    if (dwell_left !== 4'd3 || act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL force_hold_resume: dwell %0d want 3", dwell_left);
    end
    step(1, 0, 1, 2'd3);
    n_checks++;
    if ({force_ack, mode, dwell_left, mode_change} !== {1'b1, 2'd3, 4'd4, 1'b1}) begin
      n_fail++; $display("FAIL force_same_mode: got %h want ack 1 mode 3 dwell 4 mc 1", act_vec);
    end
    step(1, 0, 0, 2'd0);
  endtask

  task automatic test_async_reset();
    step(1, 0, 1, 2'd1);
    n_checks++;
    if (force_ack !== 1'b1 || act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL areset_pre: got %h want %h", act_vec, exp_vec());
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (act_vec !== 17'd0) begin
      n_fail++; $display("FAIL areset_mid: got %h want %h", act_vec, 17'd0);
    end
    enable = 1'b0; force_valid = 1'b0; pause = 1'b0;
    @(negedge clk_1) rst_n = 1'b1;
    model_reset();
    step(1, 0, 0, 2'd0);
  endtask

  task automatic test_force_expiry();
    bit found;
    logic [7:0] cnt_before;
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(1, 0, 0, 2'd0);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL fexp_seek: got %h want %h", act_vec, exp_vec());
      end
      if (mode == 2'd3 && dwell_left == 4'd1) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL fexp_reach: mode %0d dwell %0d never reached 3/1", mode, dwell_left);
    end
    cnt_before = cycle_cnt;
    step(1, 0, 1, 2'd2);
    n_checks++;
    if ({force_ack, mode, dwell_left, cycle_cnt} !== {1'b1, 2'd2, 4'd6, cnt_before} || act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL force_expiry: got %h want ack 1 mode 2 dwell 6 cnt %0d", act_vec, cnt_before);
    end
    step(1, 0, 0, 2'd0);
  endtask

  task automatic test_disable();
    logic [7:0] cnt_before;
    step(1, 0, 0, 2'd0);
    cnt_before = cycle_cnt;
    step(0, 0, 0, 2'd0);
    n_checks++;
    if ({mode, dwell_left, running, mode_change, cycle_cnt} !== {2'd0, 4'd0, 1'b0, 1'b0, cnt_before}) begin
      n_fail++; $display("FAIL disable: got %h want idle with cnt %0d", act_vec, cnt_before);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 2'd1);
      n_checks++;
      if (force_ack !== 1'b0 || act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL idle_force%0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
    step(1, 0, 1, 2'd1);
    n_checks++;
    if ({force_ack, mode, mode_change} !== {1'b0, 2'd0, 1'b1}) begin
      n_fail++; $display("FAIL enable_with_force: ack %0d mode %0d mc %0d want 0 0 1",
                         force_ack, mode, mode_change);
    end
    step(1, 0, 1, 2'd1);
    n_checks++;
    if ({force_ack, mode, dwell_left} !== {1'b1, 2'd1, 4'd8}) begin
      n_fail++; $display("FAIL run_force: ack %0d mode %0d dwell %0d want 1 1 8",
                         force_ack, mode, dwell_left);
    end
    step(1, 0, 0, 2'd0);
  endtask

  task automatic test_random();
    bit req, pz, en, pr;
    logic [1:0] rm, pm;
    req = 0; pz = 0; rm = 2'd0;
    for (int i = 0; i < 3000; i++) begin
      if (!req && $urandom_range(0, 19) == 0) begin
        req = 1;
        rm  = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 9) == 0) pz = !pz;
      en = ($urandom_range(0, 79) != 0);
      pm = mode;
      pr = running;
      step(en, pz, req, rm);
      n_checks++;
      if (act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random%0d: got %h want %h", i, act_vec, exp_vec());
      end
      if (mode_change && !force_ack && pr) begin
        n_checks++;
        if (mode === pm) begin
          n_fail++; $display("FAIL random_repeat%0d: mode %0d repeated across expiry", i, mode);
        end
      end
      if (force_ack) req = 0;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_full_cycle();
    test_pause();
    test_force_hold();
    test_async_reset();
    test_force_expiry();
    test_disable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_mode_sched.md
Name: led_mode_sched

Overview:
- Upstream stage of the LED pattern engine; produces the 2-bit `mode` that the LED pattern stage consumes.
- Runs in the 1 Hz clk_1 domain, so one cycle is one second.
- Steps automatically through modes 0→1→2→3→0. Each mode is held for a programmable dwell time, in seconds.
- Supports pause and a forced-mode request/acknowledge handshake from control logic.

Parameters:
- DWELL_W, 4, width of dwell counters and dwell_left.
- DWELL0, 8, seconds spent in mode 0 (left shift).
- DWELL1, 8, seconds spent in mode 1 (right shift).
- DWELL2, 6, seconds spent in mode 2 (blink).
- DWELL3, 4, seconds spent in mode 3 (fixed).
- Every DWELLn must satisfy 1 ≤ DWELLn ≤ 2^DWELL_W−1. A violation is an elaboration error.

Ports:
- clk_1  in  1  1 Hz clock, the sequencer clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  level; 1 runs the scheduler, 0 returns it to IDLE.
- pause  in  1  level; freezes the dwell countdown.
- force_valid  in  1  request to jump to force_mode; held until force_ack.
- force_mode  in  2  target mode; stable while force_valid=1.
- force_ack  out  1  one-cycle acknowledge of an accepted force.
- mode  out  2  current mode, to the LED pattern stage.
- mode_change  out  1  one-cycle pulse when mode is (re)loaded.
- dwell_left  out  DWELL_W  seconds remaining in the current mode, including the current second.
- cycle_cnt  out  8  count of completed 3→0 wraps; saturates at 255.
- running  out  1  1 in RUN or HOLD.

Behaviour:
- Reset values:
  - state IDLE.
  - mode=0, dwell_left=0, cycle_cnt=0.
  - mode_change=0, force_ack=0, running=0.
- All inputs are synchronous to clk_1. All outputs are registered.
- State machine: IDLE, RUN, HOLD.
- IDLE:
  - enable=1 → RUN next cycle, with mode=0, dwell_left=DWELL0, mode_change=1.
  - force_valid is ignored in IDLE (no ack).
- RUN, with pause=0:
  - If dwell_left>1, decrement dwell_left.
  - If dwell_left==1 (expiry), advance mode to mode+1 (mod 4), load dwell_left=DWELL[new mode], and pulse mode_change=1.
  - On a 3→0 expiry, increment cycle_cnt, saturating at 255.
- RUN, with pause=1:
  - → HOLD next cycle. dwell_left and mode are frozen in that cycle.
- HOLD:
  - Everything is frozen.
  - pause=0 → RUN; the countdown resumes on the following cycle.
- Force handshake, in RUN or HOLD:
  - Trigger: force_valid=1 and force_ack=0.
  - Effect: mode←force_mode, dwell_left←DWELL[force_mode], force_ack=1 and mode_change=1 for exactly one cycle.
  - State is unchanged: HOLD stays HOLD.
  - A force does not touch cycle_cnt.
  - While force_ack=1, force_valid is ignored. The requester drops force_valid after seeing the ack.
- Priority, highest first:
  1. enable=0
  2. force
  3. pause
  4. expiry
- enable=0 in any state:
  - → IDLE next cycle.
  - mode=0, dwell_left=0, running=0, no mode_change pulse.
  - cycle_cnt is retained.
- Forcing the same mode re-arms the dwell counter and still pulses mode_change.
- Asynchronous reset mid-dwell or mid-handshake restores the reset values immediately. A pending force must be re-requested.

Optional Feature:
- Macro: LED_SCHED_RANDOM_EN.
- Defined:
  - On expiry, the next mode is taken from a 7-bit maximal LFSR, x^7+x^6+1, seed 7'h5A.
  - The LFSR advances on every RUN cycle.
  - Next mode = lfsr[1:0]. If that equals the current mode, use lfsr[1:0]+1 instead, so the mode always changes.
  - cycle_cnt increments on every expiry.
- Undefined: sequential 0→1→2→3→0 advance, and no LFSR logic is generated.

Decomposition:
- Package led_sched_pkg:
  - state enum {IDLE, RUN, HOLD}.
  - mode encodings MODE_LSHIFT=0, MODE_RSHIFT=1, MODE_BLINK=2, MODE_FIXED=3.
  - dwell lookup function.
  - LFSR seed/taps constants.
- One natural sub-module: led_sched_lfsr, the 7-bit LFSR with enable. It is instantiated only under LED_SCHED_RANDOM_EN.

Test Plan:
- Reset, then enable=1 → mode=0, dwell_left=8, then 7..1. Cycle 9 after entry: mode=1, dwell_left=8, mode_change pulse.
- Full cycle (8+8+6+4=26 s) → mode returns to 0 and cycle_cnt=1. After 300 cycles (loops), cycle_cnt=255 and stays there.
- pause=1 at dwell_left=5 for 10 cycles → dwell_left stays 5 and running=1. Release → 4 on the following cycle.
- force_valid=1, force_mode=3 during HOLD → force_ack one cycle, mode=3, dwell_left=4, state still HOLD. A force coinciding with expiry wins over the auto-advance.
- enable=0 while in mode 2 → next cycle IDLE, mode=0, dwell_left=0, cycle_cnt retained. force_valid in IDLE → no ack.
- With LED_SCHED_RANDOM_EN: 64 expiries → mode never repeats across an expiry, and the sequence matches the LFSR golden model from seed 5A.
